// File: rtl/mem_stage_sb_pkg.sv
// Shared encodings for the MEM stage with store buffer: decoded ops, access sizes,
// FSM states and small op-classification helpers.
package mem_stage_sb_pkg;

  localparam int unsigned OpLen = 5;

  localparam logic [OpLen-1:0] OpNop  = 5'd0;
  localparam logic [OpLen-1:0] OpLb   = 5'd1;
  localparam logic [OpLen-1:0] OpLh   = 5'd2;
  localparam logic [OpLen-1:0] OpLw   = 5'd3;
  localparam logic [OpLen-1:0] OpLbu  = 5'd4;
  localparam logic [OpLen-1:0] OpLhu  = 5'd5;
  localparam logic [OpLen-1:0] OpSb   = 5'd6;
  localparam logic [OpLen-1:0] OpSh   = 5'd7;
  localparam logic [OpLen-1:0] OpSw   = 5'd8;
  localparam logic [OpLen-1:0] OpAddi = 5'd9;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [2:0] NBytes1 = 3'd1;
  localparam logic [2:0] NBytes2 = 3'd2;
  localparam logic [2:0] NBytes4 = 3'd4;

  localparam int unsigned SbDepthDefault = 4;

  typedef enum logic [1:0] {StIdle, StLoadWait, StStoreWait} state_e;

  function automatic logic is_load(logic [OpLen-1:0] op);
    return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
  endfunction

  function automatic logic is_store(logic [OpLen-1:0] op);
    return (op == OpSb) || (op == OpSh) || (op == OpSw);
  endfunction

  function automatic logic [2:0] op_nbytes(logic [OpLen-1:0] op);
    logic [2:0] nb;
    case (op)
      OpLb, OpLbu, OpSb: nb = NBytes1;
      OpLh, OpLhu, OpSh: nb = NBytes2;
      default:           nb = NBytes4;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/mem_stage_sb_if.sv
// Memory-controller port: one outstanding request, level req held until a done pulse.
interface mem_stage_sb_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);
  logic             mc_req_o;
  logic             mc_we_o;
  logic [AddrW-1:0] mc_addr_o;
  logic [2:0]       mc_nbytes_o;
  logic [DataW-1:0] mc_wdata_o;
  logic [DataW-1:0] mc_rdata_i;
  logic             mc_done_i;

  modport master (
    output mc_req_o, mc_we_o, mc_addr_o, mc_nbytes_o, mc_wdata_o,
    input  mc_rdata_i, mc_done_i
  );

  modport slave (
    input  mc_req_o, mc_we_o, mc_addr_o, mc_nbytes_o, mc_wdata_o,
    output mc_rdata_i, mc_done_i
  );
endinterface

// File: rtl/mem_stage_sb_store_buffer.sv
// In-order store FIFO with a parallel word-address compare across valid entries.
module mem_stage_sb_store_buffer #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [AddrW-1:0] enq_addr,
  input  logic [2:0]       enq_nbytes,
  input  logic [DataW-1:0] enq_data,
  input  logic             pop,
  input  logic [AddrW-3:0] lookup_word,
  output logic [AddrW-1:0] head_addr,
  output logic [2:0]       head_nbytes,
  output logic [DataW-1:0] head_data,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             hit
);

  logic [AddrW-1:0] addr_q   [Depth];
  logic [2:0]       nbytes_q [Depth];
  logic [DataW-1:0] data_q   [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q;

  // Enqueue and pop never target the same slot: that would need the FIFO both empty and full.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CntW'(enq) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]   <= enq_addr;
      nbytes_q[tail_q] <= enq_nbytes;
      data_q[tail_q]   <= enq_data;
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[i] && (addr_q[i][AddrW-1:2] == lookup_word)) hit = 1'b1;
    end
  end

  assign head_addr   = addr_q[head_q];
  assign head_nbytes = nbytes_q[head_q];
  assign head_data   = data_q[head_q];
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CntW'(Depth));

endmodule

// File: rtl/mem_stage_sb.sv
// RV32I MEM stage: stores retire into a FIFO that drains when the port is free; loads win the
// port but wait for any buffered store to the same word.
module mem_stage_sb
  import mem_stage_sb_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SbDepthDefault,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [OpLen-1:0]              op_i,
  input  logic [4:0]                    rd_addr_i,
  input  logic [DATA_W-1:0]             rd_data_i,
  input  logic [ADDR_W-1:0]             mem_addr_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic [4:0]                    rd_addr_o,
  output logic                          rd_enable_o,
  output logic                          mem_stall,
  mem_stage_sb_if.master                mc,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count_o
);

  state_e              state_q;
  logic                req_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          nbytes_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                sb_enq, sb_pop, sb_empty, sb_full, sb_hit;
  logic [ADDR_W-1:0]   head_addr;
  logic [2:0]          head_nbytes;
  logic [DATA_W-1:0]   head_data, store_data, rdata;
  logic                load_issue, load_done;

  always_comb begin
    unique case (op_nbytes(op_i))
      NBytes1: store_data = rd_data_i & DATA_W'(8'hFF);
      NBytes2: store_data = rd_data_i & DATA_W'(16'hFFFF);
      default: store_data = rd_data_i;
    endcase
  end

  assign sb_enq     = !rst && rdy && is_store(op_i) && !sb_full;
  assign sb_pop     = rdy && (state_q == StStoreWait) && mc.mc_done_i;
  assign load_issue = (state_q == StIdle) && is_load(op_i) && !sb_hit;
  assign load_done  = rdy && (state_q == StLoadWait) && mc.mc_done_i;

  mem_stage_sb_store_buffer #(
    .Depth (SB_DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .enq         (sb_enq),
    .enq_addr    (mem_addr_i),
    .enq_nbytes  (op_nbytes(op_i)),
    .enq_data    (store_data),
    .pop         (sb_pop),
    .lookup_word (mem_addr_i[ADDR_W-1:2]),
    .head_addr   (head_addr),
    .head_nbytes (head_nbytes),
    .head_data   (head_data),
    .count       (sb_count_o),
    .empty       (sb_empty),
    .full        (sb_full),
    .hit         (sb_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      nbytes_q <= '0;
      wdata_q  <= DATA_W'(ZeroWord);
    end else if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (load_issue) begin
            state_q  <= StLoadWait;
            req_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= mem_addr_i;
            nbytes_q <= op_nbytes(op_i);
            wdata_q  <= DATA_W'(ZeroWord);
          end else if (!sb_empty) begin
            state_q  <= StStoreWait;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            addr_q   <= head_addr;
            nbytes_q <= head_nbytes;
            wdata_q  <= head_data;
          end
        end
        StLoadWait, StStoreWait: begin
          if (mc.mc_done_i) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            nbytes_q <= '0;
            wdata_q  <= DATA_W'(ZeroWord);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mc.mc_req_o    = req_q;
  assign mc.mc_we_o     = we_q;
  assign mc.mc_addr_o   = addr_q;
  assign mc.mc_nbytes_o = nbytes_q;
  assign mc.mc_wdata_o  = wdata_q;
  assign rdata          = mc.mc_rdata_i;

  always_comb begin
    rd_data_o   = '0;
    rd_addr_o   = '0;
    rd_enable_o = 1'b0;
    mem_stall   = 1'b0;
    if (!rst) begin
      if (is_store(op_i)) begin
        mem_stall = sb_full;
      end else if (is_load(op_i)) begin
        if (load_done) begin
          rd_enable_o = 1'b1;
          rd_addr_o   = rd_addr_i;
          case (op_i)
            OpLb:    rd_data_o = {{(DATA_W-8){rdata[7]}}, rdata[7:0]};
            OpLh:    rd_data_o = {{(DATA_W-16){rdata[15]}}, rdata[15:0]};
            OpLbu:   rd_data_o = {{(DATA_W-8){1'b0}}, rdata[7:0]};
            OpLhu:   rd_data_o = {{(DATA_W-16){1'b0}}, rdata[15:0]};
            default: rd_data_o = rdata;
          endcase
        end else begin
          mem_stall = 1'b1;
        end
      end else if (op_i >= OpAddi) begin
        rd_enable_o = 1'b1;
        rd_addr_o   = rd_addr_i;
        rd_data_o   = rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: expected memory requests are queued as stimulus is driven
// and checked in order as the stage issues them.
module tb_mem_stage_sb;
  import mem_stage_sb_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  nb;
    logic [31:0] wd;
  } req_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic [OpLen-1:0] op = OpNop;
  logic [4:0]       rd_addr = '0;
  logic [31:0]      rd_data = '0;
  logic [31:0]      mem_addr = '0;
  logic [31:0]      rd_data_o;
  logic [4:0]       rd_addr_o;
  logic             rd_enable_o;
  logic             mem_stall;
  logic [2:0]       sb_count;

  int   total = 0;
  int   bad = 0;
  req_t exp_q[$];

  mem_stage_sb_if #(.AddrW(32), .DataW(32)) mc_bus ();

  mem_stage_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .op_i        (op),
    .rd_addr_i   (rd_addr),
    .rd_data_i   (rd_data),
    .mem_addr_i  (mem_addr),
    .rd_data_o   (rd_data_o),
    .rd_addr_o   (rd_addr_o),
    .rd_enable_o (rd_enable_o),
    .mem_stall   (mem_stall),
    .mc          (mc_bus),
    .sb_count_o  (sb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [OpLen-1:0] o, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] a);
    op = o;
    rd_addr = rd;
    rd_data = d;
    mem_addr = a;
    #1;
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [2:0] nb,
                      input logic [31:0] wd);
    req_t e;
    e.we = we;
    e.addr = a;
    e.nb = nb;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  // Wait for the next request, check it against the queue head, hold it, then pulse done.
  task automatic serve(input int delay, input logic [31:0] rdata, input bit wb,
                       input logic [31:0] exp_data, input logic [4:0] exp_rd, input bit clear_op);
    req_t e;
    int   n = 0;
    while (mc_bus.mc_req_o !== 1'b1 && n < 20) begin
      next();
      n++;
    end
    if (mc_bus.mc_req_o !== 1'b1) begin
      chk("req_timeout", 32'(mc_bus.mc_req_o), 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_underflow: observed=request expected=none");
      return;
    end
    e = exp_q.pop_front();
    chk("req_we", 32'(mc_bus.mc_we_o), 32'(e.we));
    chk("req_addr", mc_bus.mc_addr_o, e.addr);
    chk("req_nbytes", 32'(mc_bus.mc_nbytes_o), 32'(e.nb));
    if (e.we) chk("req_wdata", mc_bus.mc_wdata_o, e.wd);
    repeat (delay) begin
      next();
      chk("req_hold", 32'(mc_bus.mc_req_o), 32'd1);
      chk("req_hold_addr", mc_bus.mc_addr_o, e.addr);
    end
    mc_bus.mc_rdata_i = rdata;
    mc_bus.mc_done_i = 1'b1;
    #1;
    if (wb) begin
      chk("ld_wb_en", 32'(rd_enable_o), 32'd1);
      chk("ld_wb_data", rd_data_o, exp_data);
      chk("ld_wb_rd", 32'(rd_addr_o), 32'(exp_rd));
      chk("ld_done_stall", 32'(mem_stall), 32'd0);
    end else begin
      chk("st_done_no_wb", 32'(rd_enable_o), 32'd0);
    end
    next();
    mc_bus.mc_done_i = 1'b0;
    mc_bus.mc_rdata_i = '0;
    if (clear_op) op = OpNop;
    #1;
  endtask

  initial begin
    mc_bus.mc_done_i = 1'b0;
    mc_bus.mc_rdata_i = '0;

    // Reset: comb outputs forced low even with an ALU op presented.
    drive(OpAddi, 5'd5, 32'h1234, 32'h0);
    repeat (3) next();
    chk("rst_wb_en", 32'(rd_enable_o), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_req", 32'(mc_bus.mc_req_o), 32'd0);
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_addr", mc_bus.mc_addr_o, 32'd0);
    rst = 1'b0;
    #1;

    // Non-mem passthrough, then a no-writeback op.
    chk("alu_en", 32'(rd_enable_o), 32'd1);
    chk("alu_data", rd_data_o, 32'h1234);
    chk("alu_rd", 32'(rd_addr_o), 32'd5);
    chk("alu_stall", 32'(mem_stall), 32'd0);
    drive(OpNop, 5'd3, 32'h55, 32'h0);
    chk("nop_en", 32'(rd_enable_o), 32'd0);
    next();

    // Two stores enter the buffer without stalling, then drain in order.
    drive(OpSw, 5'd0, 32'hDEADBEEF, 32'h100);
    chk("sw_stall", 32'(mem_stall), 32'd0);
    chk("sw_wb", 32'(rd_enable_o), 32'd0);
    push(1'b1, 32'h100, 3'd4, 32'hDEADBEEF);
    next();
    chk("count_1", 32'(sb_count), 32'd1);
    drive(OpSb, 5'd0, 32'h123456AB, 32'h204);
    chk("sb_stall", 32'(mem_stall), 32'd0);
    push(1'b1, 32'h204, 3'd1, 32'h000000AB);
    next();
    drive(OpNop, 5'd0, 32'h0, 32'h0);
    chk("count_2", 32'(sb_count), 32'd2);
    serve(1, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("count_after_pop", 32'(sb_count), 32'd1);
    serve(0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("count_drained", 32'(sb_count), 32'd0);
    chk("req_idle", 32'(mc_bus.mc_req_o), 32'd0);

    // Full buffer: the fifth store stalls until the first drain completes.
    for (int i = 0; i < 5; i++) begin
      drive(OpSw, 5'd0, 32'hA0 + 32'(i), 32'h1000 + 32'(4 * i));
      push(1'b1, 32'h1000 + 32'(4 * i), 3'd4, 32'hA0 + 32'(i));
      if (i < 4) begin
        chk("fill_stall", 32'(mem_stall), 32'd0);
        next();
      end
    end
    chk("full_stall", 32'(mem_stall), 32'd1);
    chk("full_count", 32'(sb_count), 32'd4);
    serve(2, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("unfull_stall", 32'(mem_stall), 32'd0);
    chk("unfull_count", 32'(sb_count), 32'd3);
    next();
    drive(OpNop, 5'd0, 32'h0, 32'h0);
    chk("refill_count", 32'(sb_count), 32'd4);
    for (int i = 0; i < 4; i++) serve(0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("full_drained", 32'(sb_count), 32'd0);

    // Load to a buffered word waits for the store to drain.
    drive(OpSw, 5'd0, 32'h11223344, 32'h300);
    push(1'b1, 32'h300, 3'd4, 32'h11223344);
    next();
    drive(OpLbu, 5'd7, 32'h0, 32'h301);
    push(1'b0, 32'h301, 3'd1, 32'h0);
    chk("hazard_stall", 32'(mem_stall), 32'd1);
    serve(1, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    chk("hazard_wait_stall", 32'(mem_stall), 32'd1);
    serve(0, 32'h00000033, 1'b1, 32'h00000033, 5'd7, 1'b1);

    // Extension by load type.
    drive(OpLh, 5'd8, 32'h0, 32'h400);
    push(1'b0, 32'h400, 3'd2, 32'h0);
    serve(1, 32'h00008000, 1'b1, 32'hFFFF8000, 5'd8, 1'b1);
    drive(OpLb, 5'd9, 32'h0, 32'h404);
    push(1'b0, 32'h404, 3'd1, 32'h0);
    serve(0, 32'h00000080, 1'b1, 32'hFFFFFF80, 5'd9, 1'b1);
    drive(OpLhu, 5'd10, 32'h0, 32'h408);
    push(1'b0, 32'h408, 3'd2, 32'h0);
    serve(0, 32'h00008000, 1'b1, 32'h00008000, 5'd10, 1'b1);
    drive(OpLw, 5'd11, 32'h0, 32'h40C);
    push(1'b0, 32'h40C, 3'd4, 32'h0);
    serve(0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 5'd11, 1'b1);

    // Reset during an outstanding load also discards a buffered store.
    drive(OpSw, 5'd0, 32'h55, 32'h600);
    next();
    drive(OpLw, 5'd12, 32'h0, 32'h500);
    chk("rl_stall", 32'(mem_stall), 32'd1);
    next();
    chk("rl_req", 32'(mc_bus.mc_req_o), 32'd1);
    chk("rl_we", 32'(mc_bus.mc_we_o), 32'd0);
    chk("rl_addr", mc_bus.mc_addr_o, 32'h500);
    chk("rl_count", 32'(sb_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("rl_rst_stall", 32'(mem_stall), 32'd0);
    chk("rl_rst_wb", 32'(rd_enable_o), 32'd0);
    next();
    rst = 1'b0;
    drive(OpNop, 5'd0, 32'h0, 32'h0);
    chk("rl_req_cleared", 32'(mc_bus.mc_req_o), 32'd0);
    chk("rl_count_cleared", 32'(sb_count), 32'd0);
    mc_bus.mc_done_i = 1'b1;
    mc_bus.mc_rdata_i = 32'hFFFFFFFF;
    #1;
    chk("stale_done_wb", 32'(rd_enable_o), 32'd0);
    next();
    mc_bus.mc_done_i = 1'b0;
    #1;
    chk("stale_done_req", 32'(mc_bus.mc_req_o), 32'd0);
    next();
    chk("no_stale_drain", 32'(mc_bus.mc_req_o), 32'd0);

    // rdy low freezes state: a store is not accepted.
    rdy = 1'b0;
    drive(OpSw, 5'd0, 32'h77, 32'h700);
    next();
    chk("rdy_count", 32'(sb_count), 32'd0);
    chk("rdy_req", 32'(mc_bus.mc_req_o), 32'd0);
    rdy = 1'b1;
    drive(OpNop, 5'd0, 32'h0, 32'h0);
    next();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_sb.md
Name: mem_stage_sb

Overview:
- Next-generation MEM stage of the 5-stage RV32I pipeline (sits between EX/MEM and MEM/WB latches).
- Adds a parametrised in-order store buffer, so stores retire without stalling unless the buffer is full.
- Loads take priority over buffer drain. A conservative address-hazard check keeps memory ordering correct.
- Corrects halfword sign extension; single memory-controller port, one outstanding request.

Parameters:
SB_DEPTH, 4, store-buffer entries (power of two, >=2)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; when 0 all state holds and mc_done_i is ignored
op_i  in  OpLen  decoded op from EX/MEM
rd_addr_i  in  5  destination register
rd_data_i  in  DATA_W  ALU result (non-mem) or store data (stores)
mem_addr_i  in  ADDR_W  effective address
rd_data_o  out  DATA_W  writeback data
rd_addr_o  out  5  writeback register
rd_enable_o  out  1  writeback valid
mem_stall  out  1  hold upstream stages (combinational)
mc_req_o  out  1  memory request (registered, level, held until done)
mc_we_o  out  1  1=store, 0=load
mc_addr_o  out  ADDR_W  request address
mc_nbytes_o  out  3  1/2/4 bytes
mc_wdata_o  out  DATA_W  store data, zero-extended
mc_rdata_i  in  DATA_W  load data, valid with mc_done_i
mc_done_i  in  1  one-cycle completion pulse
sb_count_o  out  $clog2(SB_DEPTH+1)  occupied entries

Behaviour:
- Reset:
  - FSM goes to IDLE; buffer is emptied (head=tail=count=0).
  - mc_req_o/mc_we_o=0; mc_addr_o/mc_wdata_o/mc_nbytes_o=0.
  - Comb outputs are 0 while rst=1.
  - Reset mid-request abandons the request; buffered stores are discarded.
- FSM states:
  - IDLE:
    - If a non-hazard load is presented -> LOAD_WAIT.
    - Else if the buffer is non-empty -> STORE_WAIT, issuing the head entry.
  - LOAD_WAIT: mc_done_i -> IDLE.
  - STORE_WAIT: mc_done_i -> pop head, -> IDLE.
  - mc_* outputs are registered when entering a WAIT state and held stable throughout it.
- Non-mem op (op >= ADDI, not load/store):
  - rd_* pass through combinationally, rd_enable_o=1, no stall.
  - Ops below ADDI produce no writeback.
- Store (SB/SH/SW):
  - If count<SB_DEPTH at cycle start: enqueue {addr, nbytes, data masked to nbytes} at the edge; no stall; rd_enable_o=0.
  - If full: mem_stall=1. The enqueue occurs in the first cycle with count<SB_DEPTH.
  - Enqueue and pop in the same edge are allowed; count is unchanged.
- Load (LB/LH/LW/LBU/LHU):
  - Hazard: any valid entry with addr[ADDR_W-1:2] equal to mem_addr_i[ADDR_W-1:2]. Also counted as a hazard: an entry being drained in STORE_WAIT.
  - While hazard or FSM not IDLE: mem_stall=1, draining continues.
  - Otherwise issue the load (priority over drain); mem_stall=1 in LOAD_WAIT.
  - mc_done_i cycle:
    - mem_stall=0, rd_enable_o=1, rd_addr_o=rd_addr_i.
    - rd_data_o by op: LB -> sext bit7; LH -> sext bit15; LW -> as is; LBU/LHU -> zero-extend.
  - Minimum load latency: 2 cycles (op presented cycle 0, done earliest cycle 1 after mc_req_o rises).
- Drain order: strict FIFO. Pointers wrap modulo SB_DEPTH.
- Known limitation: no store-to-load forwarding; an overlapping load waits for drain.
- rdy=0: no register updates. Comb outputs still reflect current state.

Decomposition:
- Op encodings (LB..SW, ADDI), OpLen, ZERO_WORD, True/False stay in config.v.
- Add the nbytes encodings and the SB_DEPTH default there.
- Sub-module store_buffer: FIFO with enqueue/pop, count, and per-entry parallel word-address compare producing a hit flag.
- The FSM and writeback formatting stay in mem_stage_sb.

Test Plan:
- Non-mem: op=ADDI, rd_data_i=0x1234, rd_addr_i=5 -> same cycle rd_enable_o=1, rd_data_o=0x1234, mem_stall=0.
- Store drain: SW 0xDEADBEEF@0x100, then SB 0xAB@0x204, no stalls -> sb_count_o goes 1,2. Drain requests are, in order, (we=1, 0x100, 4, 0xDEADBEEF) then (0x204, 1, 0x000000AB).
- Full buffer: 5 back-to-back SW with done withheld -> mem_stall=1 on the 5th. The 5th enqueues the cycle after the first mc_done_i; count stays 4.
- Load hazard: SW 0x11223344@0x300, then LBU@0x301 -> load waits for the store done. It then issues (we=0, 0x301, 1); rdata 0x33 -> rd_data_o=0x00000033.
- Sign extension: LH with rdata 0x00008000 -> 0xFFFF8000. LB with rdata 0x80 -> 0xFFFFFF80. LHU with 0x8000 -> 0x00008000.
- Reset mid-load: LW issued, rst at cycle 2 -> next cycle mc_req_o=0, sb_count_o=0, IDLE. A later mc_done_i pulse is ignored.
